// File: rtl/da_fir_pkg.sv
// Shared types and elaboration-time helpers for the DA FIR shift-accumulate back end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, group count, output/partial/counter width derivations.
package da_fir_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Number of BAAT-bit slices that make up one input sample.
  function automatic int calc_groups(input int opsize, input int baat);
    return opsize / baat;
  endfunction

  // Full-precision output width: product of two OPSIZE-bit values, summed over
  // PARTITION partitions, plus one guard bit.
  function automatic int calc_out_w(input int opsize, input int partition);
    return 2 * opsize + $clog2(partition) + 1;
  endfunction

  // Width of one group partial: ROM word, up to 2^BAAT bit weight,
  // PARTITION-way sum, one guard bit.
  function automatic int calc_part_w(input int opsize, input int baat, input int partition);
    return opsize + baat + $clog2(partition) + 1;
  endfunction

  // Group counter width, never narrower than one bit.
  function automatic int calc_cnt_w(input int groups);
    return (groups <= 1) ? 1 : $clog2(groups);
  endfunction

endpackage

// File: rtl/da_partial_adder.sv
// Combinational weighted adder tree: P_g = sum over lanes of rom * (+/-2^b).
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs every cycle.
// Ports: lanes_i (BAAT*PARTITION signed ROM words, lane = b*PARTITION + p),
//        sign_grp_i (this slice holds the sample MSB), part_o (signed partial).
module da_partial_adder
  import da_fir_pkg::*;
#(
  parameter int OPSIZE    = 12,
  parameter int BAAT      = 3,
  parameter int PARTITION = 2,
  parameter int PW        = calc_part_w(OPSIZE, BAAT, PARTITION)
) (
  input  logic [BAAT*PARTITION-1:0][OPSIZE-1:0] lanes_i,
  input  logic                                  sign_grp_i,
  output logic signed [PW-1:0]                  part_o
);

  localparam int LANES = BAAT * PARTITION;

  logic signed [PW-1:0] sum;
  logic signed [PW-1:0] term;

  always_comb begin
    sum  = '0;
    term = '0;
    for (int j = 0; j < LANES; j++) begin
      // Sign-extend the ROM word before weighting by its bit position.
      term = PW'($signed(lanes_i[j])) <<< (j / PARTITION);
      // The top bit of the last group is the two's-complement sign bit,
      // so its bit-plane carries negative weight.
      if (sign_grp_i && ((j / PARTITION) == (BAAT - 1))) begin
        sum = sum - term;
      end else begin
        sum = sum + term;
      end
    end
    part_o = sum;
  end

endmodule

// File: rtl/da_shift_accum.sv
// Shift-accumulate back end of the DA FIR: sums ROM lanes per slice, accumulates G slices per sample.
// Latency: last slice sampled at edge E -> o_valid/o_y after edge E+1 (two register stages).
// Backpressure: none; accepts a slice on every i_valid cycle, bubbles allowed, one sample per G cycles.
// Ports: clk, rst (sync, active-high), i_valid, i_start (group 0 of a new sample),
//        i_rom_data (BAAT*PARTITION signed words), o_y (signed sample), o_valid, o_resync (strobes).
module da_shift_accum
  import da_fir_pkg::*;
#(
  parameter int OPSIZE    = 12,
  parameter int BAAT      = 3,
  parameter int PARTITION = 2,
  parameter int OUT_W     = calc_out_w(OPSIZE, PARTITION)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_valid,
  input  logic                                  i_start,
  input  logic [BAAT*PARTITION-1:0][OPSIZE-1:0] i_rom_data,
  output logic signed [OUT_W-1:0]               o_y,
  output logic                                  o_valid,
  output logic                                  o_resync
);

  localparam int G  = calc_groups(OPSIZE, BAAT);
  localparam int CW = calc_cnt_w(G);
  localparam int PW = calc_part_w(OPSIZE, BAAT, PARTITION);

  generate
    if (OPSIZE % BAAT != 0) begin : g_bad_baat
      $error("da_shift_accum: OPSIZE must be a multiple of BAAT");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Slice acceptance FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cur_grp;
  logic          accept;
  logic          resync;
  logic          is_last;
  logic          is_first;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    resync  = 1'b0;
    cur_grp = '0;

    case (state_q)
      IDLE: begin
        // A slice without i_start has no sample to belong to; drop it.
        if (i_valid && i_start) begin
          accept = 1'b1;
        end
      end
      ACCUM: begin
        if (i_valid) begin
          accept = 1'b1;
          if (i_start) begin
            // Early start abandons the partial sample; this slice becomes group 0.
            resync = 1'b1;
          end else begin
            cur_grp = cnt_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    is_last  = (cur_grp == CW'(G - 1));
    is_first = (cur_grp == '0);

    if (accept) begin
      if (is_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        cnt_d   = CW'(cur_grp + 1'b1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: weighted partial for the accepted slice
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] part;

  da_partial_adder #(
    .OPSIZE    (OPSIZE),
    .BAAT      (BAAT),
    .PARTITION (PARTITION),
    .PW        (PW)
  ) u_partial (
    .lanes_i    (i_rom_data),
    .sign_grp_i (is_last),
    .part_o     (part)
  );

  logic signed [PW-1:0] p_q;
  logic [CW-1:0]        s1_grp_q;
  logic                 s1_vld_q;
  logic                 s1_last_q;
  logic                 s1_first_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_first_q <= 1'b0;
      s1_grp_q   <= '0;
      p_q        <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        p_q        <= part;
        s1_grp_q   <= cur_grp;
        s1_last_q  <= is_last;
        s1_first_q <= is_first;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shift partial into place and accumulate
  // ---------------------------------------------------------------------------
  logic signed [OUT_W-1:0] acc_q;
  logic signed [OUT_W-1:0] y_q;
  logic                    vld_q;
  logic                    resync_q;
  logic signed [OUT_W-1:0] p_ext;
  logic signed [OUT_W-1:0] shifted;
  logic signed [OUT_W-1:0] acc_base;
  logic signed [OUT_W-1:0] acc_sum;

  always_comb begin
    p_ext    = OUT_W'(p_q);
    shifted  = p_ext <<< (int'(s1_grp_q) * BAAT);
    // Group 0 restarts the sum, which is also how a resync discards stale state.
    acc_base = s1_first_q ? '0 : acc_q;
    acc_sum  = acc_base + shifted;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      y_q      <= '0;
      vld_q    <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      vld_q    <= 1'b0;
      resync_q <= resync;
      if (s1_vld_q) begin
        if (s1_last_q) begin
          y_q   <= acc_sum;
          vld_q <= 1'b1;
          acc_q <= '0;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end
  end

  assign o_y      = y_q;
  assign o_valid  = vld_q;
  assign o_resync = resync_q;

endmodule

// File: tb/tb_da_shift_accum.sv
// Self-checking bench for da_shift_accum: directed cases plus randomized slices vs. a bit-weight model.
module tb_da_shift_accum;

  localparam int OPSIZE    = 12;
  localparam int BAAT      = 3;
  localparam int PARTITION = 2;
  localparam int OUT_W     = 2 * OPSIZE + $clog2(PARTITION) + 1;
  localparam int G         = OPSIZE / BAAT;
  localparam int LANES     = BAAT * PARTITION;

  typedef logic [LANES-1:0][OPSIZE-1:0] lanes_t;
  typedef struct {
    longint y;
    int     c;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    i_valid;
  logic                    i_start;
  lanes_t                  i_rom_data;
  logic signed [OUT_W-1:0] o_y;
  logic                    o_valid;
  logic                    o_resync;

  da_shift_accum dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_start    (i_start),
    .i_rom_data (i_rom_data),
    .o_y        (o_y),
    .o_valid    (o_valid),
    .o_resync   (o_resync)
  );

  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_pass = 0;
  int     cyc    = 0;
  exp_t   eq[$];
  int     rq[$];
  lanes_t slices[$];
  bit     active = 0;
  longint y_hold = 0;
  lanes_t pat[G];

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Sample value straight from the definition: every ROM word weighted by
  // 2^n for input bit n, with bit OPSIZE-1 weighted negatively.
  function automatic longint ref_y();
    longint y;
    y = 0;
    for (int g = 0; g < G; g++) begin
      for (int b = 0; b < BAAT; b++) begin
        for (int p = 0; p < PARTITION; p++) begin
          int     n;
          longint v;
          n = g * BAAT + b;
          v = longint'($signed(slices[g][b*PARTITION+p]));
          if (n == OPSIZE - 1) y -= v * (longint'(1) << n);
          else                 y += v * (longint'(1) << n);
        end
      end
    end
    return y;
  endfunction

  task automatic model_edge(input logic v, input logic s, input logic r, input lanes_t d);
    if (r) begin
      active = 0;
      slices.delete();
      y_hold = 0;
      for (int i = eq.size() - 1; i >= 0; i--) if (eq[i].c >= cyc) eq.delete(i);
      for (int i = rq.size() - 1; i >= 0; i--) if (rq[i] >= cyc) rq.delete(i);
    end else if (v) begin
      if (s) begin
        if (active) rq.push_back(cyc);
        slices.delete();
        active = 1;
        slices.push_back(d);
      end else if (active) begin
        slices.push_back(d);
      end
      if (active && slices.size() == G) begin
        eq.push_back('{y: ref_y(), c: cyc + 1});
        active = 0;
        slices.delete();
      end
    end
  endtask

  task automatic monitor();
    bit ev, er;
    ev = (eq.size() > 0) && (eq[0].c == cyc);
    chk("o_valid", o_valid, ev);
    if (ev) begin
      y_hold = eq[0].y;
      void'(eq.pop_front());
    end
    chk("o_y", o_y, y_hold);
    er = (rq.size() > 0) && (rq[0] == cyc);
    chk("o_resync", o_resync, er);
    if (er) void'(rq.pop_front());
  endtask

  task automatic step(input logic v, input logic s, input logic r, input lanes_t d);
    i_valid    = v;
    i_start    = s;
    rst        = r;
    i_rom_data = d;
    @(posedge clk);
    cyc++;
    model_edge(v, s, r, d);
    @(negedge clk);
    monitor();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic clear_pat();
    for (int g = 0; g < G; g++) pat[g] = '0;
  endtask

  task automatic ones_pat();
    for (int g = 0; g < G; g++)
      for (int j = 0; j < LANES; j++) pat[g][j] = OPSIZE'(1);
  endtask

  // Drive the first n groups of pat, with gap bubble cycles after each group.
  task automatic send(input int n, input int gap);
    for (int g = 0; g < n; g++) begin
      step(1'b1, (g == 0), 1'b0, pat[g]);
      idle(gap);
    end
  endtask

  initial begin
    i_valid    = 1'b0;
    i_start    = 1'b0;
    rst        = 1'b1;
    i_rom_data = '0;
    @(negedge clk);

    // Reset: all outputs zero during reset.
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b1, '1);
    idle(2);

    // All lanes 1: -2.
    ones_pat();
    send(G, 0);
    // Single lane values, back-to-back with the previous sample.
    clear_pat(); pat[0][0] = OPSIZE'(5);
    send(G, 0);
    clear_pat(); pat[2][1] = 12'hFFD;
    send(G, 0);
    // Sign bit-plane of the most negative word: +2^23.
    clear_pat(); pat[3][4] = 12'h800; pat[3][5] = 12'h800;
    send(G, 0);
    idle(2);

    // Bubbles between groups.
    ones_pat();
    send(G, 2);

    // Early start abandons a partial sample.
    ones_pat();
    send(2, 0);
    send(G, 0);
    idle(2);

    // Reset mid-sample, then a fresh sample.
    ones_pat();
    send(2, 0);
    step(1'b0, 1'b0, 1'b1, '0);
    idle(1);
    clear_pat(); pat[0][0] = OPSIZE'(7);
    send(G, 0);
    idle(3);

    // Randomized traffic with occasional resets and stray valids.
    repeat (600) begin
      lanes_t d;
      logic   v, s, r;
      for (int j = 0; j < LANES; j++) d[j] = OPSIZE'($urandom);
      r = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 75);
      s = v && ($urandom_range(0, 4) == 0);
      step(v, s, r, d);
    end

    idle(4);
    chk("drain_valid", eq.size(), 0);
    chk("drain_resync", rq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
